imm_gen_fifo: RTL and testbench

Parametrised, buffered successor to the decode-stage immediate generator. It accepts full 32-bit RISC-V instruction words over a valid/ready handshake and decodes the immediate and its format. Results are queued in a DEPTH-entry FIFO so fetch and decode can run decoupled. It supports XLEN 32/64, CSR zero-extended immediates, pipeline flush and occupancy reporting.

---
 rtl/imm_gen_fifo_pkg.sv | 21 ++
 rtl/imm_gen_fifo_decode.sv | 48 ++++
 rtl/imm_gen_fifo.sv | 61 ++++++
 tb/tb_imm_gen_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_fifo_pkg.sv
// imm_gen_fifo_pkg: RISC-V opcodes and immediate format codes shared by the decoder and FIFO
package imm_gen_fifo_pkg;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_S    = 3'd1,
      FMT_B    = 3'd2,
      FMT_U    = 3'd3,
      FMT_J    = 3'd4,
      FMT_Z    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;
endpackage

// File: rtl/imm_gen_fifo_decode.sv
// imm_decode_comb: combinational RISC-V immediate and format decoder
module imm_decode_comb
   import imm_gen_fifo_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ZEXT_CSR = 1'b1
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt
);
   logic [31:0] v;
   fmt_e        f;
   logic        unused_funct3;
   assign unused_funct3 = ^inst[13:12];
   // pick the format from the opcode and build its 32-bit sign-extended immediate
   always_comb begin
      f = FMT_NONE;
      v = {{20{inst[31]}}, inst[31:20]};
      case (inst[6:0])
         OP_LOAD, OP_IMM: f = FMT_I;
         OP_JALR: begin
            f    = FMT_I;
            v[0] = 1'b0;
         end
         OP_STORE: begin
            f = FMT_S;
            v = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         OP_BRANCH: begin
            f = FMT_B;
            v = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            f = FMT_U;
            v = {inst[31:12], 12'b0};
         end
         OP_JAL: begin
            f = FMT_J;
            v = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OP_SYSTEM: f = (ZEXT_CSR && inst[14]) ? FMT_Z : FMT_I;
         default: f = FMT_NONE;
      endcase
   end
   assign imm = (f == FMT_Z) ? XLEN'(inst[19:15]) : XLEN'($signed(v));
   assign fmt = f;
endmodule

// File: rtl/imm_gen_fifo.sv
// imm_gen_fifo: immediate decoder feeding a DEPTH-entry valid/ready FIFO
module imm_gen_fifo
   import imm_gen_fifo_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int DEPTH    = 2,
   parameter bit ZEXT_CSR = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_inst,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_imm,
   output logic [2:0]               out_fmt,
   output logic [$clog2(DEPTH):0]   out_count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = AW'(0) + (AW+1)'(DEPTH);
   logic [XLEN-1:0] mem_imm [DEPTH];
   logic [2:0]      mem_fmt [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [AW:0]     count;
   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            push, pop;
   imm_decode_comb #(.XLEN(XLEN), .ZEXT_CSR(ZEXT_CSR)) u_dec (
      .inst(in_inst),
      .imm (dec_imm),
      .fmt (dec_fmt)
   );
   assign in_ready  = !rst && (count != FULL);
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
   assign out_imm   = out_valid ? mem_imm[rptr] : '0;
   assign out_fmt   = out_valid ? mem_fmt[rptr] : '0;
   assign out_count = count;
   // entry storage: written on accepted beats, never cleared
   always_ff @(posedge clk) begin
      if (push) begin
         mem_imm[wptr] <= dec_imm;
         mem_fmt[wptr] <= dec_fmt;
      end
   end
   // pointers and occupancy; rst and flush both empty the queue ahead of push/pop
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: tb/tb_imm_gen_fifo.sv
// tb_imm_gen_fifo: directed and random checks of imm_gen_fifo against a scoreboard
module tb_imm_gen_fifo;
   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  fmt;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_imm;
   logic [2:0]  out_fmt;
   logic [1:0]  out_count;
   logic        v64 = 1'b0, rdy64, ov64;
   logic [31:0] i64 = '0;
   logic [63:0] oi64;
   logic [2:0]  of64;
   logic [1:0]  oc64;
   logic        vz = 1'b0, rdyz, ovz;
   logic [31:0] iz = '0;
   logic [31:0] oiz;
   logic [2:0]  ofz;
   logic [1:0]  ocz;
   int          pass = 0;
   int          total = 0;
   bit          mon_en = 1'b0;
   exp_t        q[$];
   imm_gen_fifo #(.XLEN(32), .DEPTH(2), .ZEXT_CSR(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt), .out_count(out_count)
   );
   imm_gen_fifo #(.XLEN(64), .DEPTH(2), .ZEXT_CSR(1'b1)) u64 (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(v64), .in_ready(rdy64),
      .in_inst(i64), .out_valid(ov64), .out_ready(1'b1),
      .out_imm(oi64), .out_fmt(of64), .out_count(oc64)
   );
   imm_gen_fifo #(.XLEN(32), .DEPTH(2), .ZEXT_CSR(1'b0)) uz0 (
      .clk(clk), .rst(rst), .flush(1'b0), .in_valid(vz), .in_ready(rdyz),
      .in_inst(iz), .out_valid(ovz), .out_ready(1'b1),
      .out_imm(oiz), .out_fmt(ofz), .out_count(ocz)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // reference decode written from the ISA field layouts using arithmetic shifts
   function automatic exp_t ref_dec(input logic [31:0] i, input bit zext);
      logic signed [31:0] r;
      exp_t e;
      r = $signed(i) >>> 20;
      e.fmt = 3'd7;
      case (i[6:0])
         7'h03, 7'h13: e.fmt = 3'd0;
         7'h67: begin e.fmt = 3'd0; r[0] = 1'b0; end
         7'h23: begin e.fmt = 3'd1; r = $signed({i[31:25], i[11:7], 20'b0}) >>> 20; end
         7'h63: begin e.fmt = 3'd2; r = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19; end
         7'h37, 7'h17: begin e.fmt = 3'd3; r = {i[31:12], 12'b0}; end
         7'h6F: begin e.fmt = 3'd4; r = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11; end
         7'h73: e.fmt = (zext && i[14]) ? 3'd5 : 3'd0;
         default: e.fmt = 3'd7;
      endcase
      e.imm = {{32{r[31]}}, r};
      if (e.fmt == 3'd5) e.imm = {59'b0, i[19:15]};
      return e;
   endfunction
   // scoreboard: push the expected result on accept, compare on pop, clear on rst/flush
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("count", 64'(out_count), 64'(q.size()));
         chk("count_le_depth", 64'(out_count <= 2'd2), 64'd1);
         chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
         chk("in_ready", 64'(in_ready), 64'(!rst && q.size() != 2));
      end
      if (rst || flush) q.delete();
      else begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("underflow", 64'd1, 64'd0);
            else begin
               e = q.pop_front();
               chk("sb_imm", 64'(out_imm), {32'b0, e.imm[31:0]});
               chk("sb_fmt", 64'(out_fmt), 64'(e.fmt));
            end
         end
         if (in_valid && in_ready) q.push_back(ref_dec(in_inst, 1'b1));
      end
   end
   logic [31:0] t_inst [6] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3, 32'h123452B7, 32'h00108067, 32'hFFF0007F};
   logic [31:0] t_imm  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000000, 32'hFFFFFFFF};
   logic [2:0]  t_fmt  [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd7};
   logic [6:0]  ops    [10] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};
   initial begin
      logic [31:0] r;
      tick;
      tick;
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_count", 64'(out_count), 64'd0);
      chk("rst_imm", 64'(out_imm), 64'd0);
      chk("rst_fmt", 64'(out_fmt), 64'd0);
      rst = 1'b0;
      mon_en = 1'b1;
      #1;
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_inst = t_inst[k];
         tick;
         chk("dir_valid", 64'(out_valid), 64'd1);
         chk("dir_imm", 64'(out_imm), 64'(t_imm[k]));
         chk("dir_fmt", 64'(out_fmt), 64'(t_fmt[k]));
      end
      in_valid = 1'b0;
      tick;
      chk("dir_empty", 64'(out_valid), 64'd0);
      v64 = 1'b1; i64 = 32'h800002B7;
      vz = 1'b1; iz = 32'h300FD073;
      tick;
      chk("x64_u_imm", oi64, 64'hFFFFFFFF80000000);
      chk("x64_u_fmt", 64'(of64), 64'd3);
      chk("z0_imm", 64'(oiz), 64'h300);
      chk("z0_fmt", 64'(ofz), 64'd0);
      i64 = 32'h300FD073; vz = 1'b0;
      tick;
      chk("x64_z_imm", oi64, 64'h1F);
      chk("x64_z_fmt", 64'(of64), 64'd5);
      v64 = 1'b0;
      tick;
      chk("x64_empty", 64'(ov64), 64'd0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00500093;
      tick;
      chk("full_a_ready", 64'(in_ready), 64'd1);
      in_inst = 32'h00600093;
      tick;
      chk("full_b_ready", 64'(in_ready), 64'd0);
      chk("full_count", 64'(out_count), 64'd2);
      in_inst = 32'h00700093;
      for (int k = 0; k < 5; k++) begin
         tick;
         chk("hold_imm", 64'(out_imm), 64'd5);
         chk("hold_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      tick;
      chk("drain_b", 64'(out_imm), 64'd6);
      tick;
      chk("drain_c", 64'(out_imm), 64'd7);
      chk("drain_c_count", 64'(out_count), 64'd1);
      in_valid = 1'b0;
      tick;
      chk("drain_empty_imm", 64'(out_imm), 64'd0);
      chk("drain_empty_fmt", 64'(out_fmt), 64'd0);
      out_ready = 1'b0;
      in_valid = 1'b1; in_inst = 32'h00500093;
      tick;
      tick;
      flush = 1'b1; in_inst = 32'h00700093;
      tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_full_valid", 64'(out_valid), 64'd0);
      chk("flush_full_count", 64'(out_count), 64'd0);
      in_valid = 1'b1; in_inst = 32'h00500093;
      tick;
      flush = 1'b1; in_inst = 32'h00700093;
      tick;
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_push_valid", 64'(out_valid), 64'd0);
      tick;
      chk("flush_drop", 64'(out_count), 64'd0);
      in_valid = 1'b1; in_inst = 32'hFFF00093;
      tick;
      in_valid = 1'b0;
      chk("pre_rst_count", 64'(out_count), 64'd1);
      rst = 1'b1;
      tick;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_count", 64'(out_count), 64'd0);
      chk("mid_rst_imm", 64'(out_imm), 64'd0);
      chk("mid_rst_fmt", 64'(out_fmt), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd0);
      rst = 1'b0;
      tick;
      chk("post_mid_rst_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 10000; k++) begin
         r = $urandom;
         in_valid = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         flush = ($urandom_range(0, 63) == 0);
         in_inst = {r[31:7], ops[$urandom_range(0, 9)]};
         tick;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 8 && out_valid; k++) tick;
      tick;
      chk("final_drain", 64'(out_valid), 64'd0);
      chk("final_sb_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end
endmodule
